// File: rtl/ov_capture_downscale_pkg.sv
// Shared definitions for the OV camera capture path: FSM encodings, default geometry
// and RGB565 field positions (also used by the VGA output selector).
package ov_capture_downscale_pkg;

  typedef enum logic [1:0] {
    ST_SKIP    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam int DEF_SRC_W       = 640;
  localparam int DEF_SRC_H       = 480;
  localparam int DEF_DEC         = 4;
  localparam int DEF_OUT_W       = 160;
  localparam int DEF_OUT_H       = 120;
  localparam int DEF_SKIP_FRAMES = 10;
  localparam int DEF_ADDR_W      = 15;

  localparam int RGB_W     = 16;
  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  // The sensor sends {R5,G3hi} then {G3lo,B5}; place the fields explicitly.
  function automatic logic [RGB_W-1:0] rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
    logic [RGB_W-1:0] p;
    p = '0;
    p[RGB_R_MSB:RGB_R_LSB] = hi[7:3];
    p[RGB_G_MSB:RGB_G_LSB] = {hi[2:0], lo[7:5]};
    p[RGB_B_MSB:RGB_B_LSB] = lo[4:0];
    return p;
  endfunction

endpackage

// File: rtl/ov_capture_downscale_edge.sv
// Registers one sensor sync line and produces single-cycle rise/fall pulses
// from the registered copy.
module cam_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= din;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/ov_capture_downscale.sv
// OV camera DVP capture with DEC x DEC decimation into a row-major RGB565 frame buffer.
// One instance per camera, entirely in the PCLK domain.
module ov_capture_downscale
  import ov_capture_downscale_pkg::*;
#(
  parameter int SRC_W       = DEF_SRC_W,
  parameter int SRC_H       = DEF_SRC_H,
  parameter int DEC         = DEF_DEC,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int OUT_H       = DEF_OUT_H,
  parameter int SKIP_FRAMES = DEF_SKIP_FRAMES,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [RGB_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              busy
);

  localparam int NPIX   = OUT_W * OUT_H;
  localparam int COL_W  = $clog2(SRC_W + 1);
  localparam int ROW_W  = $clog2(SRC_H + 1);
  localparam int CNT_W  = $clog2(NPIX + 1);
  localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);

  // Counters stop one past the active area so oversize lines/frames can never alias.
  function automatic logic [COL_W-1:0] col_sat_inc(input logic [COL_W-1:0] v);
    return (v >= COL_W'(SRC_W)) ? v : v + 1'b1;
  endfunction

  function automatic logic [ROW_W-1:0] row_sat_inc(input logic [ROW_W-1:0] v);
    return (v >= ROW_W'(SRC_H)) ? v : v + 1'b1;
  endfunction

  cap_state_t         state, state_nxt;
  logic               vsync_p0, vsync_rise, vsync_fall;
  logic               href_p0, href_rise, href_fall;
  logic [7:0]         data_p0;
  logic [7:0]         hi_byte_p1;
  logic               phase;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [CNT_W-1:0]   wr_cnt;
  logic [SKIP_W-1:0]  skip_cnt;
  logic               cap_start;
  logic               byte_vld_p0;
  logic               pix_keep;

  // ---- stage p0: registered sensor inputs and edge pulses ----
  cam_edge_detect u_vsync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (cam_vsync),
    .q    (vsync_p0),
    .rise (vsync_rise),
    .fall (vsync_fall)
  );

  cam_edge_detect u_href_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (cam_href),
    .q    (href_p0),
    .rise (href_rise),
    .fall (href_fall)
  );

  always_ff @(posedge clk) begin
    data_p0 <= cam_data;
  end

  assign cap_start   = (state == ST_WAIT) && vsync_fall;
  assign byte_vld_p0 = (state == ST_CAPTURE) && href_p0 && !vsync_p0;
  assign pix_keep    = ((col & COL_W'(DEC - 1)) == '0) && ((row & ROW_W'(DEC - 1)) == '0) &&
                       (col < COL_W'(SRC_W)) && (row < ROW_W'(SRC_H)) &&
                       (wr_cnt < CNT_W'(NPIX));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_SKIP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    busy       = 1'b0;
    unique case (state)
      ST_SKIP: begin
        if (skip_cnt == '0) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (vsync_fall) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy = 1'b1;
        if (vsync_rise) state_nxt = (wr_cnt == CNT_W'(NPIX)) ? ST_DONE : ST_WAIT;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_nxt  = ST_WAIT;
      end
      default: state_nxt = ST_SKIP;
    endcase
  end

  // ---- stage p1: byte pairing, decimation and frame-buffer write ----
  always_ff @(posedge clk) begin
    if (byte_vld_p0 && !phase) hi_byte_p1 <= data_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt <= SKIP_W'(SKIP_FRAMES);
      phase    <= 1'b0;
      col      <= '0;
      row      <= '0;
      wr_cnt   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if ((state == ST_SKIP) && vsync_rise && (skip_cnt != '0)) skip_cnt <= skip_cnt - 1'b1;
      if (cap_start) begin
        phase  <= 1'b0;
        col    <= '0;
        row    <= '0;
        wr_cnt <= '0;
      end else if (state == ST_CAPTURE) begin
        if (href_fall) begin
          // A dangling high byte from an odd-length line is simply dropped here.
          row   <= row_sat_inc(row);
          col   <= '0;
          phase <= 1'b0;
        end else if (byte_vld_p0) begin
          phase <= ~phase;
          if (phase) begin
            col <= col_sat_inc(col);
            if (pix_keep) begin
              wr_en   <= 1'b1;
              wr_addr <= ADDR_W'(wr_cnt);
              wr_data <= rgb565_pack(hi_byte_p1, data_p0);
              wr_cnt  <= wr_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = href_rise;

endmodule
